// File: rtl/fetch_unit.sv
// Instruction fetch stage with prefetch queue and IF/ID pipeline register.
// Issues word-aligned requests under a credit limit, drops stale responses after redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] in_flight_q, in_flight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   q_pc_q    [DEPTH];
    logic [31:0]   q_instr_q [DEPTH];
    logic [31:0]   ifid_instr_q, ifid_instr_d;
    logic [31:0]   ifid_pc_q, ifid_pc_d;
    logic          ifid_valid_q, ifid_valid_d;

    logic [31:0] target_pc;
    logic [CW:0] credit_used;
    logic        accept, drop, push, pop, q_empty;
    logic        unused_target_bits;

    assign target_pc          = {pc_target_e[31:2], 2'b00};
    assign unused_target_bits = ^pc_target_e[1:0];
    assign credit_used        = {1'b0, in_flight_q} + {1'b0, count_q};
    assign q_empty            = (count_q == '0);

    always_comb begin
        imem_req_valid = !reset && !stall_f && !pc_src_e && (credit_used < (CW+1)'(DEPTH));
        imem_req_addr  = fetch_pc_q;
        accept         = imem_req_valid && imem_req_ready;
        drop           = imem_rsp_valid && (discard_q != '0);
        push           = imem_rsp_valid && !drop && !pc_src_e;
        pop            = !pc_src_e && !flush_d && !stall_d && !q_empty;
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        in_flight_d = in_flight_q + CW'(accept) - CW'(imem_rsp_valid);
        discard_d   = discard_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;

        if (pc_src_e) begin
            fetch_pc_d = target_pc;
            rsp_pc_d   = target_pc;
            // in_flight already includes still-pending stale words, so everything
            // outstanding after this cycle's response becomes stale.
            discard_d  = in_flight_q - CW'(imem_rsp_valid);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
            if (drop)   discard_d  = discard_q - CW'(1);
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        if (flush_d) begin
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
        end else if (!stall_d) begin
            if (pop) begin
                ifid_instr_d = q_instr_q[rd_ptr_q];
                ifid_pc_d    = q_pc_q[rd_ptr_q];
                ifid_valid_d = 1'b1;
            end else begin
                ifid_instr_d = NOP;
                ifid_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q   <= RESET_PC;
            rsp_pc_q     <= RESET_PC;
            in_flight_q  <= '0;
            discard_q    <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            ifid_instr_q <= NOP;
            ifid_pc_q    <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            rsp_pc_q     <= rsp_pc_d;
            in_flight_q  <= in_flight_d;
            discard_q    <= discard_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            q_pc_q[wr_ptr_q]    <= rsp_pc_q;
            q_instr_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

    assign instr_d    = ifid_instr_q;
    assign pc_d       = ifid_pc_q;
    assign pc_plus4_d = ifid_pc_q + 32'd4;
    assign valid_d    = ifid_valid_q;

    queue_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PCs are queued on request acceptance,
// and compared when the IF/ID register presents a valid instruction.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP_W  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        valid_d;

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2), .NOP(NOP_W)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] model_pc;
    logic        m_valid;
    logic [31:0] m_pc, m_instr;
    logic        rsp_en;
    logic        last_req_valid, last_acc;
    logic [31:0] last_req_addr;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC3C3_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: inputs are already driven by the caller.
    task automatic tick();
        logic        s_rst, s_stall, s_flush;
        logic [31:0] e;
        #1;
        last_req_valid = imem_req_valid;
        last_req_addr  = imem_req_addr;
        last_acc       = imem_req_valid && imem_req_ready;
        if (reset || stall_f || pc_src_e) check("req_blocked", {31'd0, imem_req_valid}, 32'd0);
        if (last_acc) begin
            check("req_addr", imem_req_addr, model_pc);
            exp_q.push_back(model_pc);
            mem_q.push_back(imem_req_addr);
            model_pc = model_pc + 32'd4;
        end
        if (imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
        s_rst = reset; s_stall = stall_d; s_flush = flush_d;
        if (reset) begin
            exp_q.delete();
            mem_q.delete();
            model_pc = RST_PC;
        end else if (pc_src_e) begin
            exp_q.delete();
            model_pc = {pc_target_e[31:2], 2'b00};
        end
        @(posedge clk);
        #1;
        if (s_rst) begin
            m_valid = 1'b0; m_pc = 32'd0; m_instr = NOP_W;
        end else if (s_flush) begin
            m_valid = 1'b0; m_instr = NOP_W;
        end else if (!s_stall) begin
            if (valid_d) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'd0, valid_d}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    delivered++;
                    m_valid = 1'b1; m_pc = e; m_instr = word_of(e);
                end
            end else begin
                m_valid = 1'b0; m_instr = NOP_W;
            end
        end
        check("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
        check("pc_d", pc_d, m_pc);
        check("instr_d", instr_d, m_instr);
        check("pc_plus4_d", pc_plus4_d, m_pc + 32'd4);
        if (rsp_en && mem_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(mem_q[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid_d) break;
        end
        check(tag, {31'd0, valid_d}, 32'd1);
    endtask

    initial begin
        int d0;
        reset = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;
        rsp_en = 1'b1; model_pc = RST_PC;
        m_valid = 1'b0; m_pc = '0; m_instr = NOP_W;
        tick();
        tick();
        reset = 1'b0;

        // Startup latency from first accept to decode.
        tick();
        check("t1_first_accept", {31'd0, last_acc}, 32'd1);
        check("t1_first_addr", last_req_addr, 32'h100);
        tick();
        check("t1_not_yet", {31'd0, valid_d}, 32'd0);
        tick();
        check("t1_first_valid", {31'd0, valid_d}, 32'd1);
        check("t1_pc", pc_d, 32'h100);
        check("t1_plus4", pc_plus4_d, 32'h104);
        repeat (4) tick();

        // Decode stall fills the queue and throttles issue.
        stall_d = 1'b1;
        repeat (3) tick();
        check("t2_credit_stop", {31'd0, last_req_valid}, 32'd0);
        stall_d = 1'b0;
        repeat (6) tick();

        // Redirect with two requests outstanding.
        rsp_en = 1'b0;
        repeat (4) tick();
        check("t3_inflight_full", {31'd0, last_req_valid}, 32'd0);
        rsp_en = 1'b1; pc_src_e = 1'b1; flush_d = 1'b1; pc_target_e = 32'h0000_0203;
        tick();
        check("t3_fetch_addr", imem_req_addr, 32'h200);
        pc_src_e = 1'b0; flush_d = 1'b0;
        wait_valid("t3_wait");
        check("t3_first_pc", pc_d, 32'h200);
        repeat (3) tick();

        // Flush beats stall; queued head survives.
        stall_d = 1'b1;
        repeat (3) tick();
        flush_d = 1'b1;
        tick();
        check("t4_instr_nop", instr_d, NOP_W);
        check("t4_valid_low", {31'd0, valid_d}, 32'd0);
        flush_d = 1'b0; stall_d = 1'b0;
        tick();
        check("t4_head_delivered", {31'd0, valid_d}, 32'd1);
        repeat (2) tick();

        // Address wrap at 2^32.
        pc_src_e = 1'b1; flush_d = 1'b1; pc_target_e = 32'hFFFF_FFF8;
        tick();
        pc_src_e = 1'b0; flush_d = 1'b0;
        wait_valid("t5_wait0");
        check("t5_pc0", pc_d, 32'hFFFF_FFF8);
        wait_valid("t5_wait1");
        check("t5_pc1", pc_d, 32'hFFFF_FFFC);
        check("t5_plus4_wrap", pc_plus4_d, 32'h0000_0000);
        wait_valid("t5_wait2");
        check("t5_pc2", pc_d, 32'h0000_0000);

        // Reset with a full queue.
        stall_d = 1'b1;
        repeat (3) tick();
        reset = 1'b1; stall_d = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("t6_valid_low", {31'd0, valid_d}, 32'd0);
        check("t6_req_valid", {31'd0, last_req_valid}, 32'd1);
        check("t6_req_addr", last_req_addr, RST_PC);

        // Randomised hazards, redirects and memory back-pressure.
        d0 = delivered;
        for (int i = 0; i < 300; i++) begin
            imem_req_ready = ($urandom_range(3) != 0);
            rsp_en         = ($urandom_range(2) != 0);
            stall_f        = ($urandom_range(7) == 0);
            stall_d        = ($urandom_range(5) == 0);
            flush_d        = ($urandom_range(9) == 0);
            pc_src_e       = ($urandom_range(15) == 0);
            if (pc_src_e) begin
                flush_d     = 1'b1;
                pc_target_e = $urandom();
            end
            tick();
        end
        check("rand_progress", {31'd0, (delivered - d0) > 20}, 32'd1);

        // Stop issuing and let everything outstanding arrive.
        imem_req_ready = 1'b1; rsp_en = 1'b1; stall_f = 1'b1;
        stall_d = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
